// File: rtl/fmap_serial_arb.sv
// Captures one producer's feature map on grant and streams it element by element
// over a valid/ready port. Define FMAP_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module fmap_serial_arb #(
   parameter int BITWIDTH  = 16,
   parameter int NUM_ELEM  = 108,
   parameter int NUM_REQ   = 4,
   parameter int CNT_WIDTH = 10
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  clken,
   input  logic [NUM_REQ-1:0]                    req,
   input  logic [NUM_REQ*NUM_ELEM*BITWIDTH-1:0]  data_in,
   output logic [NUM_REQ-1:0]                    grant,
   output logic [BITWIDTH-1:0]                   out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_last,
   output logic [2:0]                            out_src,
   output logic                                  busy,
   output logic                                  done
);

   localparam int MAP_W = NUM_ELEM * BITWIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_ELEM - 1);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                state_reg, state_next;
   logic [CNT_WIDTH-1:0]  cnt_reg;
   logic [MAP_W-1:0]      buf_reg;
   logic [MAP_W-1:0]      sel_map;
   logic [NUM_REQ-1:0]    grant_reg;
   logic [NUM_REQ-1:0]    win_oh;
   logic [2:0]            src_reg;
   logic [2:0]            win;
   logic [2:0]            win_lo;
   logic                  done_reg;
   logic                  at_last;
   logic [MAP_W-1:0]      map_masked [NUM_REQ];

   // Lowest set request index; also the wrap-around fallback for round-robin.
   always_comb begin
      win_lo = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[j]) win_lo = 3'(j);
      end
   end

`ifdef FMAP_ARB_RR_EN
   logic [2:0] ptr_reg;
   logic [2:0] win_hi;
   logic       found_hi;

   // First requester at or above the pointer wins; otherwise wrap to the lowest.
   always_comb begin
      win_hi   = '0;
      found_hi = 1'b0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[j] && (3'(j) >= ptr_reg)) begin
            win_hi   = 3'(j);
            found_hi = 1'b1;
         end
      end
   end

   assign win = found_hi ? win_hi : win_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (clken && (state_reg == IDLE) && (|req)) begin
         ptr_reg <= (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
      end
   end
`else
   assign win = win_lo;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
         assign win_oh[gi]     = (win == 3'(gi));
         assign map_masked[gi] = win_oh[gi] ? data_in[gi*MAP_W +: MAP_W] : '0;
      end
   endgenerate

   always_comb begin
      sel_map = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         sel_map = sel_map | map_masked[j];
      end
   end

   assign at_last = (cnt_reg == LAST_IDX);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (|req) state_next = SEND;
         SEND:    if (out_ready && at_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else if (clken) begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         buf_reg   <= '0;
         grant_reg <= '0;
         src_reg   <= '0;
         done_reg  <= 1'b0;
      end else if (clken) begin
         grant_reg <= '0;
         done_reg  <= 1'b0;
         if ((state_reg == IDLE) && (|req)) begin
            buf_reg   <= sel_map;
            cnt_reg   <= '0;
            grant_reg <= win_oh;
            src_reg   <= win;
         end else if ((state_reg == SEND) && out_ready) begin
            if (at_last) done_reg <= 1'b1;
            else         cnt_reg  <= cnt_reg + 1'b1;
         end
      end
   end

   // Outputs are gated by state so reset drives them to zero immediately.
   assign out_valid = (state_reg == SEND);
   assign busy      = (state_reg == SEND);
   assign out_last  = out_valid && at_last;
   assign out_data  = out_valid ? buf_reg[cnt_reg*BITWIDTH +: BITWIDTH] : '0;
   assign out_src   = src_reg;
   assign grant     = grant_reg;
   assign done      = done_reg;

endmodule
